// File: rtl/codificador_pkg.sv
// Shared types, mode constants and width helper for the synchronous
// function-code encoder.
package codificador_pkg;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        CONTANDO = 2'd1,
        ESTAVEL  = 2'd2
    } estado_t;

    localparam int MODO_ESTRITO    = 32'sd0;
    localparam int MODO_PRIORIDADE = 32'sd1;

    // Ceiling log2: smallest width whose range covers 0..valor-1.
    function automatic int clog2(input int valor);
        int largura;
        int potencia;
        largura  = 32'sd0;
        potencia = 32'sd1;
        while (potencia < valor) begin
            potencia = potencia * 32'sd2;
            largura  = largura + 32'sd1;
        end
        return largura;
    endfunction

endpackage

// File: rtl/codificador_onehot_comb.sv
// Combinational request-line encoder: zero -> 0, bit i -> i+1, multi-hot
// resolved by MODO (strict gives 0, priority gives highest index+1).
module codificador_onehot_comb
    import codificador_pkg::*;
#(
    parameter int  N_ENTRADAS = 7,
    parameter int  MODO       = MODO_ESTRITO,
    localparam int W_CF       = clog2(N_ENTRADAS + 1)
) (
    input  logic [N_ENTRADAS-1:0] entradas,
    output logic [W_CF-1:0]       code,
    output logic                  multi_hot
);

    logic [5:0]      n_ativos_s;
    logic [W_CF-1:0] maior_s;

    // Count active lines and remember the highest active index.
    always_comb begin
        n_ativos_s = 6'd0;
        maior_s    = '0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            n_ativos_s = n_ativos_s + {5'd0, entradas[i]};
            maior_s    = entradas[i] ? W_CF'(i + 1) : maior_s;
        end
        multi_hot = (n_ativos_s > 6'd1);
        code      = (multi_hot && (MODO == MODO_ESTRITO)) ? '0 : maior_s;
    end

endmodule

// File: rtl/codificador_funcionalidade_sinc.sv
// Debounced, registered function-code encoder with valid/ready output,
// multi-hot error reporting and overrun detection.
module codificador_funcionalidade_sinc
    import codificador_pkg::*;
#(
    parameter int  N_ENTRADAS = 7,
    parameter int  DEBOUNCE   = 4,
    parameter int  MODO       = MODO_ESTRITO,
    localparam int W_CF       = clog2(N_ENTRADAS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_ENTRADAS-1:0] entradas,
    input  logic                  clear,
    input  logic                  cf_ready,
    output logic [W_CF-1:0]       cf,
    output logic                  cf_valid,
    output logic                  erro,
    output logic                  erro_sticky,
    output logic                  overrun
);

    localparam int               W_CNT    = clog2(DEBOUNCE + 1);
    localparam logic [W_CNT-1:0] CNT_UM   = W_CNT'(32'd1);
    localparam logic [W_CNT-1:0] CNT_ALVO = W_CNT'(DEBOUNCE);

    logic [N_ENTRADAS-1:0] amostra_r;
    logic [N_ENTRADAS-1:0] anterior_r;
    estado_t               estado_r;
    estado_t               estado_s;
    logic [W_CNT-1:0]      cnt_r;
    logic [W_CNT-1:0]      cnt_s;
    logic [W_CF-1:0]       ultimo_r;
    logic [W_CF-1:0]       cod_s;
    logic                  multi_s;
    logic                  mudou_s;
    logic                  aceita_s;
    logic                  emite_s;

    codificador_onehot_comb #(
        .N_ENTRADAS(N_ENTRADAS),
        .MODO      (MODO)
    ) u_onehot (
        .entradas (amostra_r),
        .code     (cod_s),
        .multi_hot(multi_s)
    );

    assign mudou_s = (amostra_r != anterior_r);
    // A repeated code with unchanged error level is not re-presented.
    assign emite_s = aceita_s && ((cod_s != ultimo_r) || (multi_s != erro));

    // Debounce FSM next state; acceptance happens on the edge the count hits DEBOUNCE.
    always_comb begin
        estado_s = estado_r;
        cnt_s    = cnt_r;
        aceita_s = 1'b0;
        case (estado_r)
            ESPERA, ESTAVEL: begin
                if (mudou_s) begin
                    estado_s = CONTANDO;
                    cnt_s    = CNT_UM;
                end else begin
                    estado_s = estado_r;
                    cnt_s    = cnt_r;
                end
            end
            CONTANDO: begin
                if (mudou_s) begin
                    cnt_s = CNT_UM;
                end else if (cnt_r < CNT_ALVO) begin
                    cnt_s = cnt_r + CNT_UM;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                estado_s = ESPERA;
                cnt_s    = '0;
            end
        endcase
        if ((estado_s == CONTANDO) && (cnt_s == CNT_ALVO)) begin
            estado_s = ESTAVEL;
            aceita_s = 1'b1;
        end else begin
            aceita_s = 1'b0;
        end
    end

    // Input sample, change-detection history, FSM state and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            amostra_r  <= '0;
            anterior_r <= '0;
            estado_r   <= ESPERA;
            cnt_r      <= '0;
        end else begin
            amostra_r  <= entradas;
            anterior_r <= amostra_r;
            estado_r   <= estado_s;
            cnt_r      <= cnt_s;
        end
    end

    // Last accepted code and error level.
    always_ff @(posedge clk) begin
        if (rst) begin
            ultimo_r <= '0;
            erro     <= 1'b0;
        end else if (aceita_s) begin
            ultimo_r <= cod_s;
            erro     <= multi_s;
        end else begin
            ultimo_r <= ultimo_r;
            erro     <= erro;
        end
    end

    // Output handshake: a new code always wins over a same-edge consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            cf       <= '0;
            cf_valid <= 1'b0;
        end else if (emite_s) begin
            cf       <= cod_s;
            cf_valid <= 1'b1;
        end else if (cf_valid && cf_ready) begin
            cf       <= cf;
            cf_valid <= 1'b0;
        end else begin
            cf       <= cf;
            cf_valid <= cf_valid;
        end
    end

    // Sticky flags; a set event takes priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            erro_sticky <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (aceita_s && multi_s) begin
                erro_sticky <= 1'b1;
            end else if (clear) begin
                erro_sticky <= 1'b0;
            end else begin
                erro_sticky <= erro_sticky;
            end
            if (emite_s && cf_valid && !cf_ready) begin
                overrun <= 1'b1;
            end else if (clear) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_codificador_funcionalidade_sinc.sv
// Scoreboard bench: two configurations (defaults, and 15 lines / priority /
// debounce 2) driven by directed and random stimulus against a reference model.
module tb_codificador_funcionalidade_sinc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        clear = 1'b0;
    logic [6:0]  ent0  = 7'd0;
    logic [14:0] ent1  = 15'd0;
    logic        rdy0  = 1'b0;
    logic        rdy1  = 1'b0;
    logic [2:0]  cf0;
    logic [3:0]  cf1;
    logic        v0, v1, e0, e1, s0, s1, o0, o1;

    codificador_funcionalidade_sinc dut0 (
        .clk(clk), .rst(rst), .entradas(ent0), .clear(clear), .cf_ready(rdy0),
        .cf(cf0), .cf_valid(v0), .erro(e0), .erro_sticky(s0), .overrun(o0)
    );

    codificador_funcionalidade_sinc #(.N_ENTRADAS(15), .DEBOUNCE(2), .MODO(1)) dut1 (
        .clk(clk), .rst(rst), .entradas(ent1), .clear(clear), .cf_ready(rdy1),
        .cf(cf1), .cf_valid(v1), .erro(e1), .erro_sticky(s1), .overrun(o1)
    );

    int nvec = 0;
    int nerr = 0;
    int nn[2] = '{7, 15};
    int db[2] = '{4, 2};
    int md[2] = '{0, 1};

    logic [31:0] hist [2][16];
    int          nh [2];
    logic        m_valid [2];
    logic        m_erro [2];
    logic        m_sticky [2];
    logic        m_ovr [2];
    logic [7:0]  m_last [2];
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];

    task automatic chk(input string nome, input int d, input logic [31:0] got, input logic [31:0] esp);
        nvec++;
        if (got !== esp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nome, d, got, esp);
        end
    endtask

    // Code = highest set index + 1 (i.e. clog2(v+1)); strict mode zeroes multi-hot.
    function automatic logic [7:0] enc(input logic [31:0] v, input int n, input int modo, output logic multi);
        logic [31:0] m;
        m     = v & ((32'd1 << n) - 32'd1);
        multi = ($countones(m) > 1);
        if (multi && modo == 0) return 8'd0;
        return 8'($clog2({32'd0, m} + 64'd1));
    endfunction

    function automatic logic [7:0] obs_cf(input int d);
        return (d == 0) ? {5'd0, cf0} : {4'd0, cf1};
    endfunction

    function automatic logic [3:0] obs_fl(input int d);
        return (d == 0) ? {v0, e0, s0, o0} : {v1, e1, s1, o1};
    endfunction

    // Reference model: a vector is accepted D edges after the sample in which it
    // first appeared, provided it stayed unchanged for D samples.
    task automatic modelo(input int d, input logic rs, input logic c, input logic rdy, input logic [31:0] samp);
        logic        acc, emit, multi, was_valid, set_ovr;
        logic [7:0]  code;
        logic [31:0] alvo;
        if (rs) begin
            for (int j = 0; j < 16; j++) hist[d][j] = 32'd0;
            nh[d] = 1;
            m_valid[d] = 1'b0; m_erro[d] = 1'b0; m_sticky[d] = 1'b0;
            m_ovr[d] = 1'b0; m_last[d] = 8'd0;
        end else begin
            for (int j = 15; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = samp;
            if (nh[d] < 100) nh[d]++;
            alvo = hist[d][1];
            acc  = (nh[d] >= db[d] + 2);
            for (int j = 1; j <= db[d]; j++) if (hist[d][j] != alvo) acc = 1'b0;
            if (hist[d][db[d]+1] == alvo) acc = 1'b0;
            emit = 1'b0; multi = 1'b0; code = 8'd0;
            if (acc) begin
                code = enc(alvo, nn[d], md[d], multi);
                emit = (code != m_last[d]) || (multi != m_erro[d]);
                m_last[d] = code;
                m_erro[d] = multi;
            end
            was_valid = m_valid[d];
            set_ovr   = emit && was_valid && !rdy;
            if (emit) begin
                m_valid[d] = 1'b1;
                if (d == 0) q0.push_back({multi, code}); else q1.push_back({multi, code});
            end else if (was_valid && rdy) begin
                m_valid[d] = 1'b0;
            end
            m_sticky[d] = (acc && multi) ? 1'b1 : (c ? 1'b0 : m_sticky[d]);
            m_ovr[d]    = set_ovr ? 1'b1 : (c ? 1'b0 : m_ovr[d]);
        end
    endtask

    task automatic verifica(input int d, input logic rs);
        logic [3:0] f;
        f = obs_fl(d);
        chk("cf_valid",    d, {31'd0, f[3]}, {31'd0, m_valid[d]});
        chk("erro",        d, {31'd0, f[2]}, {31'd0, m_erro[d]});
        chk("erro_sticky", d, {31'd0, f[1]}, {31'd0, m_sticky[d]});
        chk("overrun",     d, {31'd0, f[0]}, {31'd0, m_ovr[d]});
        if (rs) chk("cf_reset", d, {24'd0, obs_cf(d)}, 32'd0);
    endtask

    task automatic step(input logic [31:0] a0, input logic [31:0] a1, input logic r0, input logic r1,
                        input logic c, input logic rs);
        ent0 = a0[6:0]; ent1 = a1[14:0]; rdy0 = r0; rdy1 = r1; clear = c; rst = rs;
        @(posedge clk);
        #1;
        modelo(0, rs, c, r0, {25'd0, a0[6:0]});
        modelo(1, rs, c, r1, {17'd0, a1[14:0]});
        verifica(0, rs);
        verifica(1, rs);
    endtask

    task automatic hold(input logic [31:0] a0, input logic [31:0] a1, input logic r0, input logic r1,
                        input logic c, input logic rs, input int n);
        for (int k = 0; k < n; k++) step(a0, a1, r0, r1, c, rs);
    endtask

    function automatic logic [31:0] pick(input int n);
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = 32'd0;
            1, 2:    v = 32'd1 << $urandom_range(0, n - 1);
            default: v = $urandom() & ((32'd1 << n) - 32'd1);
        endcase
        return v;
    endfunction

    // Monitor: every newly presented {erro, cf} must match the next queued expectation.
    initial begin
        logic       pv [2];
        logic [8:0] pp [2];
        logic [8:0] cur, esp;
        logic       vld;
        pv[0] = 1'b0; pv[1] = 1'b0; pp[0] = 9'd0; pp[1] = 9'd0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vld = (d == 0) ? v0 : v1;
                cur = {((d == 0) ? e0 : e1), obs_cf(d)};
                if (vld && (!pv[d] || cur != pp[d])) begin
                    if (d == 0 && q0.size() > 0) begin
                        esp = q0.pop_front();
                        chk("cf_saida", d, {23'd0, cur}, {23'd0, esp});
                    end else if (d == 1 && q1.size() > 0) begin
                        esp = q1.pop_front();
                        chk("cf_saida", d, {23'd0, cur}, {23'd0, esp});
                    end else begin
                        chk("saida_inesperada", d, {23'd0, cur}, 32'hffff_ffff);
                    end
                end
                pv[d] = vld;
                pp[d] = cur;
            end
        end
    end

    initial begin
        logic [31:0] a0, a1;
        int          h0, h1;
        hold(32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        // single line held with ready high, then release
        hold(32'h01, 32'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        hold(32'h00, 32'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        // bouncing top line, then stable
        for (int i = 0; i < 5; i++)
            hold((i % 2 == 0) ? 32'h40 : 32'h00, (i % 2 == 0) ? 32'h4000 : 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        hold(32'h40, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        // multi-hot, then clear together with a valid vector
        hold(32'h14, 32'h0014, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        hold(32'h04, 32'h4000, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        hold(32'h04, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        // consumer stalled: overwrite, then one ready cycle
        hold(32'h02, 32'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        hold(32'h08, 32'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        hold(32'h08, 32'h0008, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        hold(32'h08, 32'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        // reset in the middle of a debounce, then post-reset latency
        hold(32'h20, 32'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        hold(32'h20, 32'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        hold(32'h00, 32'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        hold(32'h20, 32'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 7);
        // random traffic
        h0 = 0; h1 = 0; a0 = 32'd0; a1 = 32'd0;
        for (int c = 0; c < 800; c++) begin
            if (h0 == 0) begin a0 = pick(7);  h0 = $urandom_range(1, 8); end
            if (h1 == 0) begin a1 = pick(15); h1 = $urandom_range(1, 5); end
            h0--; h1--;
            step(a0, a1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0);
        end
        hold(32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12);
        @(negedge clk);
        chk("fila_vazia", 0, q0.size(), 32'd0);
        chk("fila_vazia", 1, q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/codificador_funcionalidade_sinc.md
CODIFICADOR_FUNCIONALIDADE_SINC -- requirements
Module: codificador_funcionalidade_sinc

Interface
REQ-001 Parameter N_ENTRADAS, default 7, number of one-hot request lines (2..32).
REQ-002 Parameter DEBOUNCE, default 4, consecutive identical samples required before a code is accepted (1..255).
REQ-003 Parameter MODO, default 0: 0 = strict one-hot, 1 = highest-index priority.
REQ-004 Derived W_CF = clog2(N_ENTRADAS+1), default 3; not user-overridable.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 entradas  input  N_ENTRADAS  request lines; bit 0 = first function (code 1), bit i = code i+1.
REQ-009 clear  input  1  clears sticky flags.
REQ-010 cf_ready  input  1  consumer accepts cf this cycle.
REQ-011 cf  output  W_CF  accepted function code, registered.
REQ-012 cf_valid  output  1  cf holds an unconsumed code.
REQ-013 erro  output  1  level; last accepted vector was multi-hot.
REQ-014 erro_sticky  output  1  set on any accepted multi-hot vector; held until clear.
REQ-015 overrun  output  1  sticky; an unconsumed code was overwritten.

Function
REQ-016 Encode: zero vector -> code 0; single bit i -> i+1; multi-hot -> 0 when MODO=0, highest set index+1 when MODO=1.
REQ-017 entradas SHALL be registered once (amostra); no combinational path from inputs to outputs.
REQ-018 FSM states ESPERA, CONTANDO, ESTAVEL; reset state ESPERA.
REQ-019 ESPERA/ESTAVEL -> CONTANDO when amostra differs from previous amostra; counter loads 1.
REQ-020 CONTANDO: counter increments each edge with unchanged amostra; any change reloads 1 and stays CONTANDO.
REQ-021 CONTANDO -> ESTAVEL when counter reaches DEBOUNCE; vector accepted on that edge.
REQ-022 Latency: vector applied before edge k, held constant -> cf/cf_valid update at edge k+DEBOUNCE.
REQ-023 Acceptance SHALL emit a new cf/cf_valid only if the encoded code differs from the last accepted code, or erro changes.
REQ-024 erro SHALL update with each acceptance; erro_sticky sets on the same edge.
REQ-025 cf_valid set on acceptance; cleared on the edge after cf_valid&cf_ready; cf stable while cf_valid&!cf_ready.
REQ-026 Acceptance while cf_valid&!cf_ready: cf overwritten, cf_valid stays 1, overrun set.
REQ-027 Acceptance on same edge as cf_valid&cf_ready: new code loaded, cf_valid stays 1, overrun not set.
REQ-028 clear and a new set event on the same edge: set wins.
REQ-029 Counter saturates at DEBOUNCE; width clog2(DEBOUNCE+1).

Reset
REQ-030 rst at any edge SHALL force cf=0, cf_valid=0, erro=0, erro_sticky=0, overrun=0, amostra=0, last code=0, counter=0, state ESPERA, overriding all other inputs, including mid-debounce and mid-handshake.
REQ-031 After rst release, the first nonzero vector SHALL follow REQ-022 timing.

Structure
REQ-032 Package codificador_pkg SHALL hold the FSM state enum, MODO_ESTRITO/MODO_PRIORIDADE constants, and the clog2 width function.
REQ-033 Sub-module codificador_onehot_comb SHALL implement REQ-016 combinationally (parameters N_ENTRADAS, MODO), outputs code and multi-hot flag.

Verification
REQ-034 Defaults, entradas=7'b0000001 held 6 cycles, cf_ready=1 -> cf=1, cf_valid high exactly one cycle at edge k+4.
REQ-035 entradas=7'b1000000 toggling every 2 cycles for 10 cycles, then held -> no cf_valid until 4 stable samples, then cf=7.
REQ-036 MODO=0, entradas=7'b0010100 held -> cf=0, erro=1, erro_sticky=1; clear pulse with valid vector 7'b0000100 -> cf=3, erro=0, erro_sticky=0.
REQ-037 MODO=1, entradas=7'b0010100 -> cf=5, erro=1.
REQ-038 cf_ready=0, accept 7'b0000010 then 7'b0001000 -> cf=4, cf_valid=1, overrun=1; cf_ready=1 one cycle -> cf_valid=0.
REQ-039 rst asserted at counter=2 -> all outputs 0 next edge; N_ENTRADAS=15 build, bit 14 -> cf=15 with W_CF=4.
